// File: rtl/riscv_writeback_scoreboard.sv
// Writeback stage and load scoreboard in front of the 32x32 register file.
// Optional feature: define WB_BYPASS_EN to add writeback bypass ports and bypass-aware stall.
module riscv_writeback_scoreboard #(
  parameter int LOAD_DEPTH = 4,
  parameter int WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          reset_trigger_n,
  input  logic                          issue_valid,
  input  logic                          issue_is_load,
  input  logic [4:0]                    issue_rs1,
  input  logic [4:0]                    issue_rs2,
  input  logic [4:0]                    issue_rd,
  output logic                          issue_stall,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [WIDTH-1:0]              alu_value,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [WIDTH-1:0]              mem_value,
  output logic [4:0]                    rd,
  output logic                          write_trigger,
  output logic [WIDTH-1:0]              write_value,
  output logic [$clog2(LOAD_DEPTH):0]   loads_pending,
  output logic                          mem_error
`ifdef WB_BYPASS_EN
  ,
  output logic                          bypass_valid,
  output logic [4:0]                    bypass_rd,
  output logic [WIDTH-1:0]              bypass_value
`endif
);

  localparam int PTR_W = $clog2(LOAD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LOAD_DEPTH);

  typedef struct packed {
    logic             valid;
    logic [4:0]       rd;
    logic [WIDTH-1:0] value;
  } wb_result_t;

  logic [4:0]       fifo_rd [LOAD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic [31:0]      busy_view;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             alu_accept;
  wb_result_t       result;

  assign fifo_full     = (count == FULL_CNT);
  assign fifo_empty    = (count == '0);
  assign loads_pending = count;
  assign alu_ready     = ~mem_valid;
  assign alu_accept    = alu_valid & alu_ready;
  assign pop           = mem_valid & ~fifo_empty;
  assign push          = issue_valid & ~issue_stall & issue_is_load;

`ifdef WB_BYPASS_EN
  assign bypass_valid = write_trigger;
  assign bypass_rd    = rd;
  assign bypass_value = write_value;
`endif

  // Busy bits as seen by the hazard check; a bypassed register counts as ready.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    busy_view = busy;
`ifdef WB_BYPASS_EN
    if (write_trigger) busy_view[rd] = 1'b0;
`endif
  end

  assign issue_stall = issue_valid & (busy_view[issue_rs1] | busy_view[issue_rs2] |
                                      busy_view[issue_rd] | (issue_is_load & fifo_full));

  // Load responses win the single write port; the ALU waits via alu_ready.
  always_comb begin
    result = '0;
    if (pop) begin
      result.valid = 1'b1;
      result.rd    = fifo_rd[rd_ptr];
      result.value = mem_value;
    end else if (alu_accept) begin
      result.valid = 1'b1;
      result.rd    = alu_rd;
      result.value = alu_value;
    end
  end

  // Clear on commit, then set on load issue so a coincident set wins.
  always_comb begin
    busy_next = busy;
    if (write_trigger) busy_next[rd] = 1'b0;
    if (push)          busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: the rd storage needs no reset; entries are only read between a push and its pop.
  always_ff @(posedge clk) begin
    if (push) fifo_rd[wr_ptr] <= issue_rd;
  end

  always_ff @(posedge clk or negedge reset_trigger_n) begin
    if (!reset_trigger_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      busy          <= '0;
      mem_error     <= 1'b0;
      rd            <= '0;
      write_value   <= '0;
      write_trigger <= 1'b0;
    end else begin
      busy <= busy_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mem_valid && fifo_empty) mem_error <= 1'b1;
      write_trigger <= result.valid & (result.rd != 5'd0);
      if (result.valid) begin
        rd          <= result.rd;
        write_value <= result.value;
      end
    end
  end

endmodule

// File: tb/tb_riscv_writeback_scoreboard.sv
// Directed self-checking bench for riscv_writeback_scoreboard (default LOAD_DEPTH=4, WIDTH=32).
module tb_riscv_writeback_scoreboard;

  logic        clk = 1'b0;
  logic        reset_trigger_n;
  logic        issue_valid, issue_is_load;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        alu_ready;
  logic        mem_valid;
  logic [31:0] mem_value;
  logic [4:0]  rd;
  logic        write_trigger;
  logic [31:0] write_value;
  logic [2:0]  loads_pending;
  logic        mem_error;
`ifdef WB_BYPASS_EN
  logic        bypass_valid;
  logic [4:0]  bypass_rd;
  logic [31:0] bypass_value;
`endif

  int errors = 0;
  int checks = 0;

  riscv_writeback_scoreboard #(.LOAD_DEPTH(4), .WIDTH(32)) dut (
    .clk(clk),
    .reset_trigger_n(reset_trigger_n),
    .issue_valid(issue_valid),
    .issue_is_load(issue_is_load),
    .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2),
    .issue_rd(issue_rd),
    .issue_stall(issue_stall),
    .alu_valid(alu_valid),
    .alu_rd(alu_rd),
    .alu_value(alu_value),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid),
    .mem_value(mem_value),
    .rd(rd),
    .write_trigger(write_trigger),
    .write_value(write_value),
    .loads_pending(loads_pending),
    .mem_error(mem_error)
`ifdef WB_BYPASS_EN
    ,
    .bypass_valid(bypass_valid),
    .bypass_rd(bypass_rd),
    .bypass_value(bypass_value)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One rising edge; returns at the following falling edge where outputs are stable.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_trigger_n = 1'b0;
    issue_valid = 1'b0; issue_is_load = 1'b0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_value = 32'd0;
    mem_valid = 1'b0; mem_value = 32'd0;
    step();
    step();
    check("rst_wt", write_trigger, 0);
    check("rst_rd", rd, 0);
    check("rst_val", write_value, 0);
    check("rst_pending", loads_pending, 0);
    check("rst_err", mem_error, 0);
    check("rst_alu_ready", alu_ready, 1);
    reset_trigger_n = 1'b1;
    step();

    // ALU path to x3
    alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 32'h12345678;
    #1 check("alu_ready_idle", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    check("alu_wt", write_trigger, 1);
    check("alu_rd", rd, 3);
    check("alu_val", write_value, 32'h12345678);
    step();
    check("alu_wt_one_cycle", write_trigger, 0);

    // ALU path to x0
    alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 32'hAAAA5555;
    step();
    alu_valid = 1'b0;
    check("alu_x0_wt", write_trigger, 0);
    step();
    check("alu_x0_wt_after", write_trigger, 0);

    // Load RAW on x10
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd10;
    #1 check("ld10_no_stall", issue_stall, 0);
    step();
    issue_is_load = 1'b0; issue_rs1 = 5'd10; issue_rd = 5'd11;
    #1 check("raw_stall", issue_stall, 1);
    check("raw_pending", loads_pending, 1);
    step();
    check("raw_stall_held", issue_stall, 1);
    mem_valid = 1'b1; mem_value = 32'hABCDEF01;
    step();
    mem_valid = 1'b0;
    check("raw_wt", write_trigger, 1);
    check("raw_rd", rd, 10);
    check("raw_val", write_value, 32'hABCDEF01);
    check("raw_pending_0", loads_pending, 0);
`ifdef WB_BYPASS_EN
    #1 check("raw_stall_bypass", issue_stall, 0);
    check("bypass_rd", bypass_rd, 10);
    check("bypass_val", bypass_value, 32'hABCDEF01);
`else
    #1 check("raw_stall_nobypass", issue_stall, 1);
`endif
    step();
    check("raw_wt_done", write_trigger, 0);
    check("raw_stall_released", issue_stall, 0);
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rd = 5'd0;

    // Collision: load response to x7 against ALU result to x5
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    mem_valid = 1'b1; mem_value = 32'h11110000;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_value = 32'hDEADBEEF;
    #1 check("col_alu_ready", alu_ready, 0);
    step();
    mem_valid = 1'b0;
    check("col_ld_wt", write_trigger, 1);
    check("col_ld_rd", rd, 7);
    check("col_ld_val", write_value, 32'h11110000);
    #1 check("col_alu_ready_back", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    check("col_alu_wt", write_trigger, 1);
    check("col_alu_rd", rd, 5);
    check("col_alu_val", write_value, 32'hDEADBEEF);
    step();
    check("col_idle", write_trigger, 0);

    // FIFO full: loads to x1..x4, fifth load stalls even with a pop this cycle
    issue_valid = 1'b1; issue_is_load = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      issue_rd = 5'(i);
      #1 check("full_push_ok", issue_stall, 0);
      step();
    end
    issue_rd = 5'd5;
    #1 check("full_stall", issue_stall, 1);
    check("full_pending", loads_pending, 4);
    mem_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      mem_value = 32'hD0000000 + 32'(i);
      if (i == 1) #1 check("full_stall_with_pop", issue_stall, 1);
      step();
      if (i == 1) issue_valid = 1'b0;
      check("full_wt", write_trigger, 1);
      check("full_rd", rd, 32'(i));
      check("full_val", write_value, 32'hD0000000 + 32'(i));
      check("full_pending_dec", loads_pending, 32'(4 - i));
    end
    mem_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;

    // Load to x0: pushes and pops but never writes
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd0;
    step();
    issue_valid = 1'b0; issue_is_load = 1'b0;
    check("x0_ld_pending", loads_pending, 1);
    mem_valid = 1'b1; mem_value = 32'h0BADF00D;
    step();
    mem_valid = 1'b0;
    check("x0_ld_wt", write_trigger, 0);
    check("x0_ld_pending_0", loads_pending, 0);
    check("x0_ld_no_err", mem_error, 0);

    // Orphan response
    mem_valid = 1'b1; mem_value = 32'h00000BAD;
    step();
    mem_valid = 1'b0;
    check("orphan_wt", write_trigger, 0);
    check("orphan_err", mem_error, 1);
    check("orphan_pending", loads_pending, 0);
    step();
    step();
    check("orphan_err_sticky", mem_error, 1);

    // Reset mid-run with two loads pending and a write in flight
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd8;
    step();
    issue_rd = 5'd9;
    step();
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = 5'd0;
    check("pre_rst_pending", loads_pending, 2);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_value = 32'hCAFEF00D;
    step();
    alu_valid = 1'b0;
    check("pre_rst_wt", write_trigger, 1);
    reset_trigger_n = 1'b0;
    issue_valid = 1'b1; issue_rs1 = 5'd8; issue_rs2 = 5'd9;
    #1 check("mid_rst_wt", write_trigger, 0);
    check("mid_rst_rd", rd, 0);
    check("mid_rst_val", write_value, 0);
    check("mid_rst_pending", loads_pending, 0);
    check("mid_rst_err", mem_error, 0);
    check("mid_rst_busy_clear", issue_stall, 0);
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    step();
    reset_trigger_n = 1'b1;
    step();
    mem_valid = 1'b1; mem_value = 32'h12121212;
    step();
    mem_valid = 1'b0;
    check("post_rst_orphan_err", mem_error, 1);
    check("post_rst_orphan_wt", write_trigger, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
